// File: rtl/vscale_rr_arbiter.sv
// Shared data-memory arbiter for NUM_CORES HASTI masters with a round-robin grant,
// hmastlock support and separate address-phase/data-phase ownership.
module vscale_rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2,
    parameter int ADDR_W    = 32,
    parameter int BUS_W     = 32,
    parameter int EXT_SEL   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_haddr,
    input  logic [NUM_CORES-1:0]          core_hwrite,
    input  logic [NUM_CORES*3-1:0]        core_hsize,
    input  logic [NUM_CORES*3-1:0]        core_hburst,
    input  logic [NUM_CORES-1:0]          core_hmastlock,
    input  logic [NUM_CORES*4-1:0]        core_hprot,
    input  logic [NUM_CORES*2-1:0]        core_htrans,
    input  logic [NUM_CORES*BUS_W-1:0]    core_hwdata,
    output logic [NUM_CORES*BUS_W-1:0]    core_hrdata,
    output logic [NUM_CORES-1:0]          core_hready,
    output logic [NUM_CORES-1:0]          core_hresp,
    output logic [ADDR_W-1:0]             dmem_haddr,
    output logic                          dmem_hwrite,
    output logic [2:0]                    dmem_hsize,
    output logic [2:0]                    dmem_hburst,
    output logic                          dmem_hmastlock,
    output logic [3:0]                    dmem_hprot,
    output logic [1:0]                    dmem_htrans,
    output logic [BUS_W-1:0]              dmem_hwdata,
    input  logic [BUS_W-1:0]              dmem_hrdata,
    input  logic                          dmem_hready,
    input  logic                          dmem_hresp,
    input  logic [IDX_W-1:0]              next_core,
    output logic [IDX_W-1:0]              cur_core,
    output logic [IDX_W-1:0]              data_core,
    output logic                          data_valid
);

    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [IDX_W-1:0]     data_q;
    logic                 valid_q;
    logic [NUM_CORES-1:0] req;
    logic                 cur_req;
    logic                 cur_lock;
    logic [IDX_W-1:0]     rr_grant;
    logic                 rr_found;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = core_htrans[2*i+1];
        end
    end

    // Address-phase mux follows cur_q, write-data mux follows data_q.
    always_comb begin
        cur_req        = 1'b0;
        cur_lock       = 1'b0;
        dmem_haddr     = '0;
        dmem_hwrite    = 1'b0;
        dmem_hsize     = '0;
        dmem_hburst    = '0;
        dmem_hmastlock = 1'b0;
        dmem_hprot     = '0;
        dmem_htrans    = '0;
        dmem_hwdata    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cur_q == IDX_W'(i)) begin
                cur_req        = req[i];
                cur_lock       = core_hmastlock[i];
                dmem_haddr     = core_haddr[i*ADDR_W +: ADDR_W];
                dmem_hwrite    = core_hwrite[i];
                dmem_hsize     = core_hsize[i*3 +: 3];
                dmem_hburst    = core_hburst[i*3 +: 3];
                dmem_hmastlock = core_hmastlock[i];
                dmem_hprot     = core_hprot[i*4 +: 4];
                dmem_htrans    = core_htrans[i*2 +: 2];
            end
            if (data_q == IDX_W'(i)) begin
                dmem_hwdata = core_hwdata[i*BUS_W +: BUS_W];
            end
        end
    end

    // Scan cur+1, cur+2, ... with cur itself last.
    always_comb begin
        rr_grant = cur_q;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!rr_found && req[i] && ((int'(cur_q) + k) % NUM_CORES) == i) begin
                    rr_grant = IDX_W'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_d = cur_q;
        if (cur_lock && cur_req) begin
            cur_d = cur_q;
        end else if (EXT_SEL != 0) begin
            if (int'(next_core) < NUM_CORES) begin
                cur_d = next_core;
            end
        end else if (rr_found) begin
            cur_d = rr_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (dmem_hready) begin
            cur_q   <= cur_d;
            data_q  <= cur_q;
            valid_q <= cur_req;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_hready[i] = dmem_hready &
                             ((cur_q == IDX_W'(i)) | (valid_q & (data_q == IDX_W'(i))));
            core_hresp[i]  = dmem_hresp & valid_q & (data_q == IDX_W'(i));
        end
    end

    assign core_hrdata = {NUM_CORES{dmem_hrdata}};
    assign cur_core    = cur_q;
    assign data_core   = data_q;
    assign data_valid  = valid_q;

endmodule
